// File: rtl/wb_regfile_scoreboard.sv
// wb_regfile_scoreboard
//
// Write-back end of the datapath. It holds a 32 x DATA_W register file that
// takes destination writes from two producers, memory and ALU. Memory has
// fixed priority, and at most one array write happens per cycle. A scoreboard
// tracks which destinations are still in flight. Decode is told to stall on a
// RAW hazard (a source operand is pending) or a WAW hazard (the new
// destination is pending).
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   rs_addr/rt_addr         operand read addresses
//   rs_used/rt_used         operand is actually consumed by the decoding instr
//   rs_data/rt_data         combinational read data, bypassed from the write
//   iss_valid/iss_reg       decode issues an instruction writing iss_reg
//   stall                   hazard detected, decode must hold
//   alu_wvalid/wreg/wdata   ALU write-back request, alu_wready handshake
//   mem_wvalid/wreg/wdata   memory write-back request, mem_wready handshake
//   busy_mask               registered scoreboard, bit n = reg n pending

module wb_regfile_scoreboard #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  input  logic              rs_used,
  input  logic              rt_used,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              iss_valid,
  input  logic [4:0]        iss_reg,
  output logic              stall,
  input  logic              alu_wvalid,
  input  logic [4:0]        alu_wreg,
  input  logic [DATA_W-1:0] alu_wdata,
  output logic              alu_wready,
  input  logic              mem_wvalid,
  input  logic [4:0]        mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wready,
  output logic [31:0]       busy_mask
);

  localparam int NREG = 32;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;

  logic              wr_en;
  logic              wr_hit;
  logic [4:0]        wr_reg;
  logic [DATA_W-1:0] wr_data;
  logic [NREG-1:0]   clr_mask;
  logic [NREG-1:0]   set_mask;
  logic [NREG-1:0]   eff_busy;

  // The memory path can always complete. The ALU path only completes when
  // memory is silent, so the write selected here is the single accepted one.
  assign mem_wready = 1'b1;
  assign alu_wready = !mem_wvalid;

  // Choose the one accepted write. A write to register 0 still completes its
  // handshake, but wr_hit drops it so that it neither updates the array nor
  // touches the scoreboard.
  always_comb begin
    wr_en   = mem_wvalid || alu_wvalid;
    wr_reg  = mem_wvalid ? mem_wreg  : alu_wreg;
    wr_data = mem_wvalid ? mem_wdata : alu_wdata;
    wr_hit  = wr_en && (wr_reg != 5'd0);
  end

  // A write that completes this cycle already resolves its hazard. Its busy
  // bit is therefore masked out before the stall check.
  always_comb begin
    clr_mask = '0;
    if (wr_hit) clr_mask[wr_reg] = 1'b1;
    eff_busy = busy & ~clr_mask;
  end

  // Hazard check. Bit 0 of busy is never set, so register 0 cannot stall.
  // An issue is recorded only when it is not stalled.
  always_comb begin
    stall = iss_valid && ((rs_used && eff_busy[rs_addr]) ||
                          (rt_used && eff_busy[rt_addr]) ||
                          eff_busy[iss_reg]);
    set_mask = '0;
    if (iss_valid && !stall && (iss_reg != 5'd0)) set_mask[iss_reg] = 1'b1;
  end

  // Read ports. Register 0 is hard zero. A matching write in flight is
  // forwarded so that decode sees the value in the same cycle.
  always_comb begin
    if (rs_addr == 5'd0)                  rs_data = '0;
    else if (wr_hit && wr_reg == rs_addr) rs_data = wr_data;
    else                                  rs_data = regs[rs_addr];
  end

  always_comb begin
    if (rt_addr == 5'd0)                  rt_data = '0;
    else if (wr_hit && wr_reg == rt_addr) rt_data = wr_data;
    else                                  rt_data = regs[rt_addr];
  end

  // Array and scoreboard state. The set mask is OR-ed in after the clear
  // mask, so an issue wins over a same-cycle completion to the same register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_hit) regs[wr_reg] <= wr_data;
      busy <= (busy & ~clr_mask) | set_mask;
    end
  end

  assign busy_mask = busy;

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// tb_wb_regfile_scoreboard
//
// Scoreboard bench for wb_regfile_scoreboard. A reference model holds the
// register contents and the pending set. Each applied cycle pushes the
// expected outputs into a queue, and a separate monitor pops one entry and
// compares it on every falling edge.

module tb_wb_regfile_scoreboard;

  typedef struct packed {
    logic        reset;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        rs_used;
    logic        rt_used;
    logic        iss_valid;
    logic [4:0]  iss_reg;
    logic        alu_wvalid;
    logic [4:0]  alu_wreg;
    logic [31:0] alu_wdata;
    logic        mem_wvalid;
    logic [4:0]  mem_wreg;
    logic [31:0] mem_wdata;
  } stim_t;

  typedef struct packed {
    logic        chk_data;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        stall;
    logic        alu_ready;
    logic [31:0] busy;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [4:0]  rs_addr, rt_addr;
  logic        rs_used, rt_used;
  logic [31:0] rs_data, rt_data;
  logic        iss_valid;
  logic [4:0]  iss_reg;
  logic        stall;
  logic        alu_wvalid;
  logic [4:0]  alu_wreg;
  logic [31:0] alu_wdata;
  logic        alu_wready;
  logic        mem_wvalid;
  logic [4:0]  mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_wready;
  logic [31:0] busy_mask;

  int total = 0;
  int bad   = 0;

  exp_t exp_q[$];

  // Reference state: the register contents and the set of pending registers.
  logic [31:0] m_regs [32];
  bit          m_pend [32];

  wb_regfile_scoreboard #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_used(rs_used), .rt_used(rt_used),
    .rs_data(rs_data), .rt_data(rt_data),
    .iss_valid(iss_valid), .iss_reg(iss_reg), .stall(stall),
    .alu_wvalid(alu_wvalid), .alu_wreg(alu_wreg), .alu_wdata(alu_wdata),
    .alu_wready(alu_wready),
    .mem_wvalid(mem_wvalid), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_wready(mem_wready),
    .busy_mask(busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expectation and compares it on each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("busy_mask", busy_mask, e.busy);
        check_output("stall", {31'd0, stall}, {31'd0, e.stall});
        check_output("alu_wready", {31'd0, alu_wready}, {31'd0, e.alu_ready});
        check_output("mem_wready", {31'd0, mem_wready}, 32'd1);
        if (e.chk_data) begin
          check_output("rs_data", rs_data, e.rs);
          check_output("rt_data", rt_data, e.rt);
        end
      end
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Drives one cycle. When chk is set, the expected outputs come from the
  // model and are queued. The model then advances at the rising edge.
  task automatic apply_stimulus(input stim_t s, input bit chk);
    exp_t        e;
    bit          w;
    logic [4:0]  wreg;
    logic [31:0] wdat;
    bit          pend_rs, pend_rt, pend_iss, st;

    reset      = s.reset;
    rs_addr    = s.rs_addr;    rt_addr    = s.rt_addr;
    rs_used    = s.rs_used;    rt_used    = s.rt_used;
    iss_valid  = s.iss_valid;  iss_reg    = s.iss_reg;
    alu_wvalid = s.alu_wvalid; alu_wreg   = s.alu_wreg; alu_wdata = s.alu_wdata;
    mem_wvalid = s.mem_wvalid; mem_wreg   = s.mem_wreg; mem_wdata = s.mem_wdata;

    // Memory wins. The ALU write only goes through when memory is idle.
    w = 0; wreg = 5'd0; wdat = 32'd0;
    if (s.mem_wvalid)      begin w = 1; wreg = s.mem_wreg; wdat = s.mem_wdata; end
    else if (s.alu_wvalid) begin w = 1; wreg = s.alu_wreg; wdat = s.alu_wdata; end
    if (wreg == 5'd0) w = 0;

    pend_rs  = m_pend[s.rs_addr] && !(w && wreg == s.rs_addr);
    pend_rt  = m_pend[s.rt_addr] && !(w && wreg == s.rt_addr);
    pend_iss = m_pend[s.iss_reg] && !(w && wreg == s.iss_reg);
    st = s.iss_valid && ((s.rs_used && pend_rs) || (s.rt_used && pend_rt) || pend_iss);

    e.chk_data  = !s.reset;
    e.rs        = (s.rs_addr == 0) ? 32'd0 : (w && wreg == s.rs_addr) ? wdat : m_regs[s.rs_addr];
    e.rt        = (s.rt_addr == 0) ? 32'd0 : (w && wreg == s.rt_addr) ? wdat : m_regs[s.rt_addr];
    e.stall     = st;
    e.alu_ready = !s.mem_wvalid;
    for (int n = 0; n < 32; n++) e.busy[n] = m_pend[n];
    if (chk) exp_q.push_back(e);

    @(posedge clk);
    if (s.reset) begin
      for (int n = 0; n < 32; n++) begin m_regs[n] = 32'd0; m_pend[n] = 0; end
    end else begin
      if (w) begin m_regs[wreg] = wdat; m_pend[wreg] = 0; end
      if (s.iss_valid && !st && s.iss_reg != 0) m_pend[s.iss_reg] = 1;
    end
    #1;
  endtask

  initial begin
    stim_t s, prev;
    int    waited;

    for (int n = 0; n < 32; n++) begin m_regs[n] = 32'd0; m_pend[n] = 0; end

    // Initial reset. The DUT state is unknown before it, so nothing is queued.
    s = idle(); s.reset = 1;
    apply_stimulus(s, 0);
    apply_stimulus(s, 1);

    // Fill the array, reset for one cycle, then read every register back.
    for (int r = 1; r < 32; r++) begin
      s = idle(); s.alu_wvalid = 1; s.alu_wreg = 5'(r); s.alu_wdata = $urandom;
      apply_stimulus(s, 1);
    end
    s = idle(); s.reset = 1;
    apply_stimulus(s, 1);
    for (int r = 0; r < 16; r++) begin
      s = idle(); s.rs_addr = 5'(2*r); s.rt_addr = 5'(2*r+1);
      apply_stimulus(s, 1);
    end

    // Bypass on an ALU write, then the same read from the array.
    s = idle(); s.alu_wvalid = 1; s.alu_wreg = 5; s.alu_wdata = 32'hDEADBEEF; s.rs_addr = 5;
    apply_stimulus(s, 1);
    s = idle(); s.rs_addr = 5;
    apply_stimulus(s, 1);
    // A write to register 0 is dropped.
    s = idle(); s.alu_wvalid = 1; s.alu_wreg = 0; s.alu_wdata = 32'h1234; s.rs_addr = 0; s.rt_addr = 0;
    apply_stimulus(s, 1);
    apply_stimulus(idle(), 1);

    // RAW on a load destination, resolved by the memory write.
    s = idle(); s.iss_valid = 1; s.iss_reg = 8;
    apply_stimulus(s, 1);
    s = idle(); s.iss_valid = 1; s.iss_reg = 11; s.rt_addr = 8; s.rt_used = 1;
    apply_stimulus(s, 1);
    apply_stimulus(s, 1);
    s.mem_wvalid = 1; s.mem_wreg = 8; s.mem_wdata = 32'h55;
    apply_stimulus(s, 1);
    s = idle(); s.alu_wvalid = 1; s.alu_wreg = 11; s.alu_wdata = 32'h11;
    apply_stimulus(s, 1);

    // Both producers at once. Memory goes first and the ALU completes later.
    s = idle(); s.mem_wvalid = 1; s.mem_wreg = 3; s.mem_wdata = 32'h333;
    s.alu_wvalid = 1; s.alu_wreg = 4; s.alu_wdata = 32'h444; s.rs_addr = 3; s.rt_addr = 4;
    apply_stimulus(s, 1);
    s.mem_wvalid = 0;
    apply_stimulus(s, 1);
    s = idle(); s.rs_addr = 3; s.rt_addr = 4;
    apply_stimulus(s, 1);

    // WAW stall, then an issue that wins over a same-cycle completion.
    s = idle(); s.iss_valid = 1; s.iss_reg = 9;
    apply_stimulus(s, 1);
    apply_stimulus(s, 1);
    s = idle(); s.iss_valid = 1; s.iss_reg = 10; s.alu_wvalid = 1; s.alu_wreg = 9; s.alu_wdata = 32'h99;
    apply_stimulus(s, 1);
    s = idle(); s.iss_valid = 1; s.iss_reg = 10; s.alu_wvalid = 1; s.alu_wreg = 10; s.alu_wdata = 32'hA0;
    apply_stimulus(s, 1);
    s = idle(); s.mem_wvalid = 1; s.mem_wreg = 10; s.mem_wdata = 32'hA1;
    apply_stimulus(s, 1);

    // A reset clears a pending register, so reading it no longer stalls.
    s = idle(); s.iss_valid = 1; s.iss_reg = 12;
    apply_stimulus(s, 1);
    s = idle(); s.reset = 1;
    apply_stimulus(s, 1);
    s = idle(); s.iss_valid = 1; s.iss_reg = 13; s.rs_addr = 12; s.rs_used = 1;
    apply_stimulus(s, 1);

    // Random traffic with hazard-prone addresses and occasional resets.
    prev = idle();
    for (int c = 0; c < 3000; c++) begin
      s = idle();
      s.reset     = ($urandom_range(0, 199) == 0);
      s.rs_addr   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      s.rt_addr   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      s.rs_used   = 1'($urandom);
      s.rt_used   = 1'($urandom);
      s.iss_valid = ($urandom_range(0, 9) < 4);
      s.iss_reg   = 5'($urandom_range(0, 7));
      s.mem_wvalid = ($urandom_range(0, 9) < 4);
      s.mem_wreg   = 5'($urandom_range(0, 7));
      s.mem_wdata  = $urandom;
      // A blocked ALU producer keeps its request stable.
      if (prev.alu_wvalid && prev.mem_wvalid) begin
        s.alu_wvalid = 1; s.alu_wreg = prev.alu_wreg; s.alu_wdata = prev.alu_wdata;
      end else begin
        s.alu_wvalid = ($urandom_range(0, 9) < 5);
        s.alu_wreg   = 5'($urandom_range(0, 7));
        s.alu_wdata  = $urandom;
      end
      apply_stimulus(s, 1);
      prev = s;
    end
    apply_stimulus(idle(), 1);

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d entries left expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_regfile_scoreboard.md
# wb_regfile_scoreboard

Write-back end of the datapath: a 32×32-bit register file that accepts destination-register writes from the ALU and memory write-back paths. It tracks in-flight destinations in a scoreboard and raises a decode stall on RAW or WAW hazards. It sits downstream of the RegDst destination-select mux (which produces `alu_wreg`/`iss_reg`) and upstream of the decode stage's operand reads.

## Interface
- `DATA_W`, 32, register width
- `clk`  input  1  single clock, rising edge
- `reset`  input  1  synchronous, active-high
- `rs_addr`, `rt_addr`  input  5  read addresses
- `rs_used`, `rt_used`  input  1  operand actually consumed by decoding instruction
- `rs_data`, `rt_data`  output  32  read data (combinational, with bypass)
- `iss_valid`  input  1  decode issues an instruction that writes `iss_reg`
- `iss_reg`  input  5  destination chosen by RegDst
- `stall`  output  1  hazard; decode must hold
- `alu_wvalid`  input  1, `alu_wreg`  input  5, `alu_wdata`  input  32, `alu_wready`  output  1
- `mem_wvalid`  input  1, `mem_wreg`  input  5, `mem_wdata`  input  32, `mem_wready`  output  1
- `busy_mask`  output  32  scoreboard state (bit n = reg n pending)

## Operation
- Register 0 reads 0 always; writes to 0 are accepted (handshake completes) but discarded; busy[0] is never set.
- Write arbitration, fixed priority memory > ALU:
  - `mem_wready` = 1 constantly.
  - `alu_wready` = !`mem_wvalid`.
  - A write is accepted on valid && ready. At most one array write per cycle.
- Accepted write, reg ≠ 0: array[reg] ← data at clock edge; busy[reg] cleared at the same edge.
- Scoreboard set: `iss_valid` && !`stall` && `iss_reg` ≠ 0 → busy[iss_reg] ← 1.
- Same-cycle set and clear of the same register: set wins (bit ends 1).
- Bypass: when an accepted write (reg ≠ 0) matches `rs_addr`/`rt_addr`, the read port returns the incoming write data instead of the array value.
- Effective busy: eb[n] = busy[n] && !(accepted write to n this cycle).
- Stall (combinational) = `iss_valid` && ((`rs_used` && eb[rs_addr]) || (`rt_used` && eb[rt_addr]) || eb[iss_reg]).
  - The last term is the WAW check.
  - Register 0 never causes a stall.
- When `stall` = 1, nothing is registered from the issue side.
- A write to a non-busy register is legal: the array updates and busy is unchanged.

## Timing
- Reset (synchronous, while `reset` high at a rising edge):
  - All 32 array entries ← 0 and busy ← 0.
  - Writes and issues in that cycle are ignored (handshakes still report ready).
- After reset: `rs_data` = `rt_data` = 0, `busy_mask` = 0, `stall` = 0, `alu_wready` = !`mem_wvalid`, `mem_wready` = 1.
- Reset asserted mid-operation clears all pending busy bits. Write-back units must not rely on completion of pre-reset writes.
- Write latency:
  - Data is visible on read ports in the same cycle via bypass.
  - Data is in the array from the next cycle.
  - The busy bit reads 0 in `busy_mask` from the next cycle; `stall` reflects the clear in the same cycle.
- Issue latency: busy bit visible in `busy_mask` and in `stall` from the cycle after issue.
- Handshake: a producer holding `alu_wvalid` while `alu_wready` = 0 must keep `alu_wreg`/`alu_wdata` stable; the block has no write buffering.
- All outputs other than `busy_mask` are combinational from inputs and state. `busy_mask` is a direct register output.

## Test plan
- Reset with array pre-written → after one reset cycle, reads of regs 1..31 return 0, `busy_mask` = 0, `stall` = 0.
- ALU write reg 5 = 0xDEADBEEF with `rs_addr` = 5 same cycle → `rs_data` = 0xDEADBEEF that cycle (bypass), and still 0xDEADBEEF next cycle from the array. Write reg 0 = 0x1234 → reads of reg 0 return 0.
- Issue load to reg 8; next cycle issue reading `rt_addr` = 8 (`rt_used` = 1):
  - `stall` = 1 and `busy_mask[8]` = 1.
  - In the cycle `mem_wvalid` writes reg 8 = 0x55: `stall` = 0 and `rt_data` = 0x55.
- `mem_wvalid` and `alu_wvalid` both high (regs 3, 4) → `alu_wready` = 0, only reg 3 is written. Next cycle with mem idle, `alu_wready` = 1 and reg 4 is written.
- WAW: reg 9 busy, `iss_valid` with `iss_reg` = 9 → `stall` = 1. Same-cycle issue to reg 10 while a write to reg 10 completes → `busy_mask[10]` = 1 afterwards.
- Reg 12 busy, assert `reset` for one cycle → `busy_mask` = 0, and a subsequent read of reg 12 with `rs_used` = 1 does not stall.
